// File: rtl/adc128s022_pkg.sv
// Shared types and frame constants for the ADC128S022 serial ADC controller.
package adc128s022_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int FRAME_BITS  = 16;
  localparam int DATA_BITS   = 12;
  localparam int LEAD_BITS   = 4;
  localparam int ADDR_BIT_HI = 2;
  localparam int ADDR_BIT_LO = 4;
  localparam int NUM_PHASES  = 32;

  // Address bit presented on SADDR for frame bit idx: chan[2], chan[1], chan[0] on bits 2..4.
  function automatic logic addr_bit(input logic [2:0] chan, input logic [3:0] idx);
    logic b;
    b = 1'b0;
    for (int k = 0; k <= ADDR_BIT_LO - ADDR_BIT_HI; k++) begin
      if (int'(idx) == ADDR_BIT_HI + k) b = chan[2-k];
    end
    return b;
  endfunction

endpackage

// File: rtl/adc128s022_tick.sv
// Half-period timer: emits a one-cycle tick every HALF_DIV clocks, re-aligned on restart.
module adc128s022_tick
  import adc128s022_pkg::*;
#(
  parameter int HALF_DIV = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] RELOAD = 8'(HALF_DIV - 1);

  logic [7:0] cnt;

  // Down-counter; restart loads a full half-period so the first tick lands HALF_DIV cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || cnt == 8'd0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

  assign tick = (cnt == 8'd0);

endmodule

// File: rtl/adc128s022_ctrl.sv
// ADC128S022 initiator: one request -> one 16-bit SPI frame -> one tagged 12-bit sample.
module adc128s022_ctrl
  import adc128s022_pkg::*;
#(
  parameter int HALF_DIV = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [2:0]  req_chan,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [2:0]  rsp_chan,
  output logic [11:0] rsp_data,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_saddr,
  input  logic        adc_sdat
);

  state_t                  state, state_nxt;
  logic [5:0]              phase, phase_nxt;
  logic                    cs_nxt, sclk_nxt, saddr_nxt;
  logic [FRAME_BITS-1:0]   shift, shift_nxt;
  logic [2:0]              chan, chan_nxt;
  logic [2:0]              prev_chan, prev_nxt;
  logic                    rsp_valid_nxt;
  logic [2:0]              rsp_chan_nxt;
  logic [DATA_BITS-1:0]    rsp_data_nxt;
  logic                    sdat_p0;
  logic                    start;
  logic                    tick;

  adc128s022_tick #(
    .HALF_DIV (HALF_DIV)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (start),
    .tick    (tick)
  );

  assign req_ready = (state == ST_IDLE);

  // Input synchroniser flop for the serial data line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sdat_p0 <= 1'b0;
    else        sdat_p0 <= adc_sdat;
  end

  // State and registered pin/response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      phase     <= '0;
      adc_cs_n  <= 1'b1;
      adc_sclk  <= 1'b1;
      adc_saddr <= 1'b0;
      shift     <= '0;
      chan      <= '0;
      prev_chan <= '0;
      rsp_valid <= 1'b0;
      rsp_chan  <= '0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      adc_cs_n  <= cs_nxt;
      adc_sclk  <= sclk_nxt;
      adc_saddr <= saddr_nxt;
      shift     <= shift_nxt;
      chan      <= chan_nxt;
      prev_chan <= prev_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_chan  <= rsp_chan_nxt;
      rsp_data  <= rsp_data_nxt;
    end
  end

  // Next-state and next-output logic; every transition after the accept happens on a tick.
  always_comb begin
    state_nxt     = state;
    phase_nxt     = phase;
    cs_nxt        = adc_cs_n;
    sclk_nxt      = adc_sclk;
    saddr_nxt     = adc_saddr;
    shift_nxt     = shift;
    chan_nxt      = chan;
    prev_nxt      = prev_chan;
    rsp_valid_nxt = 1'b0;
    rsp_chan_nxt  = rsp_chan;
    rsp_data_nxt  = rsp_data;
    start         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          start     = 1'b1;
          chan_nxt  = req_chan;
          state_nxt = ST_SETUP;
          phase_nxt = '0;
          cs_nxt    = 1'b0;
          sclk_nxt  = 1'b1;
          saddr_nxt = 1'b0;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_nxt = ST_SHIFT;
          phase_nxt = 6'd1;
          sclk_nxt  = 1'b0;
          saddr_nxt = addr_bit(chan, 4'd0);
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (phase == 6'(NUM_PHASES)) begin
            // Frame complete: release CS with SCLK high and publish the sample.
            state_nxt     = ST_HOLD;
            cs_nxt        = 1'b1;
            sclk_nxt      = 1'b1;
            saddr_nxt     = 1'b0;
            rsp_valid_nxt = 1'b1;
            rsp_data_nxt  = shift[DATA_BITS-1:0];
            rsp_chan_nxt  = prev_chan;
            prev_nxt      = chan;
          end else begin
            phase_nxt = phase + 6'd1;
            if (phase[0]) begin
              // Entering an even phase: rising SCLK, capture the flopped data bit.
              sclk_nxt  = 1'b1;
              shift_nxt = {shift[FRAME_BITS-2:0], sdat_p0};
            end else begin
              // Entering an odd phase: falling SCLK, present the next address bit.
              sclk_nxt  = 1'b0;
              saddr_nxt = addr_bit(chan, phase[4:1]);
            end
          end
        end
      end
      ST_HOLD: begin
        if (tick) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_adc128s022_ctrl.sv
// Bench for adc128s022_ctrl: table-driven requests, ADC pin model and response scoreboard.
module tb_adc128s022_ctrl;

  localparam int H       = 2;
  localparam int LAT     = 1 + 33 * H;
  localparam int SPACING = 34 * H + 1;
  localparam int CSLOW   = 33 * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_chan = 3'd0;
  logic        req_ready;
  logic        rsp_valid;
  logic [2:0]  rsp_chan;
  logic [11:0] rsp_data;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_saddr;
  logic        adc_sdat = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0]  addr_chan;
    logic [2:0]  exp_chan;
    logic [11:0] exp_data;
    int          acc;
  } sb_t;

  typedef struct {
    logic [2:0]  chan;
    logic [15:0] word;
    logic [2:0]  exp_chan;
    logic [11:0] exp_data;
    bit          b2b;
  } vec_t;

  sb_t         sb[$];
  logic [15:0] word_q[$];

  adc128s022_ctrl #(.HALF_DIV(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_chan  (req_chan),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_chan  (rsp_chan),
    .rsp_data  (rsp_data),
    .adc_cs_n  (adc_cs_n),
    .adc_sclk  (adc_sclk),
    .adc_saddr (adc_saddr),
    .adc_sdat  (adc_sdat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_addr(input logic [2:0] c);
    logic [15:0] v;
    v = 16'h0;
    v[2] = c[2];
    v[3] = c[1];
    v[4] = c[0];
    return v;
  endfunction

  // ADC pin model (drives SDAT after falling SCLK) plus frame monitor and scoreboard pop.
  logic        prev_cs = 1'b1, prev_sclk = 1'b1;
  logic [15:0] cur_word = 16'h0;
  logic [15:0] addr_bits = 16'h0;
  int          cs_low = 0, rises = 0, falls = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      cs_low = 0; rises = 0; falls = 0; addr_bits = 16'h0;
      prev_cs = 1'b1; prev_sclk = 1'b1; adc_sdat = 1'b0;
    end else begin
      if (prev_cs && !adc_cs_n) begin
        cur_word = (word_q.size() != 0) ? word_q.pop_front() : 16'h0;
        falls = 0; rises = 0; cs_low = 0; addr_bits = 16'h0;
      end
      if (!adc_cs_n) begin
        cs_low++;
        if (!prev_sclk && adc_sclk) begin
          if (rises < 16) addr_bits[rises] = adc_saddr;
          rises++;
        end
        if (prev_sclk && !adc_sclk) begin
          if (falls < 16) adc_sdat = cur_word[15-falls];
          falls++;
        end
      end else begin
        adc_sdat = 1'b0;
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          sb_t it;
          it = sb.pop_front();
          chk("rsp_chan", int'(rsp_chan), int'(it.exp_chan));
          chk("rsp_data", int'(rsp_data), int'(it.exp_data));
          chk("rsp_latency", cyc - it.acc, LAT);
          chk("cs_low_cycles", cs_low, CSLOW);
          chk("sclk_rises", rises, 16);
          chk("saddr_bits", int'(addr_bits), int'(exp_addr(it.addr_chan)));
        end
        cs_low = 0; rises = 0;
      end
      prev_cs = adc_cs_n;
      prev_sclk = adc_sclk;
    end
  end

  task automatic do_req(input logic [2:0] ch, input logic [15:0] word,
                        input logic [2:0] exp_ch, output int acc);
    req_valid = 1'b1;
    req_chan  = ch;
    acc = -1;
    for (int n = 0; n < 500 && acc < 0; n++) begin
      @(negedge clk);
      if (req_ready) acc = cyc;
    end
    if (acc < 0) begin
      chk("accept_timeout", 0, 1);
    end else begin
      sb.push_back('{addr_chan: ch, exp_chan: exp_ch, exp_data: word[11:0], acc: acc});
      word_q.push_back(word);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_chan  = 3'($urandom);
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && sb.size() != 0; n++) @(negedge clk);
    chk("rsp_outstanding", sb.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs_n"}, int'(adc_cs_n), 1);
    chk({tag, "_sclk"}, int'(adc_sclk), 1);
    chk({tag, "_saddr"}, int'(adc_saddr), 0);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_rsp_data"}, int'(rsp_data), 0);
    chk({tag, "_rsp_chan"}, int'(rsp_chan), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vec[6];
    int   acc, prev_acc;
    int   accs[3];
    int   nacc;

    vec[0] = '{chan: 3'd5, word: 16'h0ABC, exp_chan: 3'd0, exp_data: 12'hABC, b2b: 1'b0};
    vec[1] = '{chan: 3'd3, word: 16'h0123, exp_chan: 3'd5, exp_data: 12'h123, b2b: 1'b1};
    vec[2] = '{chan: 3'd7, word: 16'h0FFF, exp_chan: 3'd3, exp_data: 12'hFFF, b2b: 1'b0};
    vec[3] = '{chan: 3'd1, word: 16'hF000, exp_chan: 3'd7, exp_data: 12'h000, b2b: 1'b0};
    vec[4] = '{chan: 3'd4, word: 16'h0FFF, exp_chan: 3'd1, exp_data: 12'hFFF, b2b: 1'b0};
    vec[5] = '{chan: 3'd0, word: 16'h05A5, exp_chan: 3'd4, exp_data: 12'h5A5, b2b: 1'b0};

    // Power-on reset.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);
    chk("por_req_ready", int'(req_ready), 1);
    @(posedge clk); #1;

    // Table-driven frames, including one back-to-back pair.
    prev_acc = 0;
    for (int i = 0; i < 6; i++) begin
      do_req(vec[i].chan, vec[i].word, vec[i].exp_chan, acc);
      if (i > 0 && vec[i-1].b2b) chk("b2b_spacing", acc - prev_acc, SPACING);
      prev_acc = acc;
      if (!vec[i].b2b) drain();
    end

    // req_valid held with chan 6; req_chan disturbed while busy.
    req_valid = 1'b1;
    nacc = 0;
    for (int n = 0; n < 400 && nacc < 3; n++) begin
      req_chan = req_ready ? 3'd6 : 3'd1;
      @(negedge clk);
      if (req_ready) begin
        logic [15:0] w;
        w = (nacc == 0) ? 16'h0321 : (nacc == 1) ? 16'hC456 : 16'h0789;
        sb.push_back('{addr_chan: 3'd6, exp_chan: (nacc == 0) ? 3'd0 : 3'd6,
                       exp_data: w[11:0], acc: cyc});
        word_q.push_back(w);
        accs[nacc] = cyc;
        nacc++;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("held_accepts", nacc, 3);
    if (nacc == 3) begin
      chk("held_spacing1", accs[1] - accs[0], SPACING);
      chk("held_spacing2", accs[2] - accs[1], SPACING);
    end
    drain();

    // Reset during phase 10 aborts the frame; channel history restarts at 0.
    do_req(3'd3, 16'h0FFF, 3'd6, acc);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    sb.delete();
    word_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", int'(req_ready), 1);
    @(posedge clk); #1;
    do_req(3'd2, 16'h0777, 3'd0, acc);
    drain();
    do_req(3'd5, 16'h0246, 3'd2, acc);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
